// File: rtl/car_bank.sv
// Bank of NREGS counter/address registers with per-register inc/dec/load/add
// and two combinational read ports (address port with displacement, X-bus port).
module car_bank #(
    parameter int              WIDTH     = 16,
    parameter int              NREGS     = 5,
    parameter int              SEL_W     = 3,
    parameter int              DISP_W    = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic              clock,
    input  logic              clear,
    input  logic [NREGS-1:0]  inc,
    input  logic [NREGS-1:0]  dec,
    input  logic [NREGS-1:0]  load,
    input  logic [NREGS-1:0]  add,
    input  logic [WIDTH-1:0]  xbus_in,
    input  logic [DISP_W-1:0] offset,
    input  logic [SEL_W-1:0]  addr_sel,
    input  logic              addr_oe,
    input  logic [DISP_W-1:0] addr_disp,
    input  logic [SEL_W-1:0]  xbus_sel,
    input  logic              xbus_oe,
    output logic [WIDTH-1:0]  addr_out,
    output logic              addr_drive,
    output logic [WIDTH-1:0]  xbus_out,
    output logic              xbus_drive,
    output logic [NREGS-1:0]  wrap,
    output logic              sel_err
);

    logic [WIDTH-1:0] regs_q [NREGS];
    logic [WIDTH-1:0] regs_d [NREGS];
    logic [NREGS-1:0] wrap_q, wrap_d;
    logic             sel_err_q, sel_err_d;

    logic [WIDTH-1:0] off_ext;
    logic [WIDTH-1:0] disp_ext;
    logic             add_carry;
    logic             addr_bad, xbus_bad;
    logic [WIDTH-1:0] addr_reg, xbus_reg;

    assign off_ext  = WIDTH'($signed(offset));
    assign disp_ext = WIDTH'($signed(addr_disp));

    always_comb begin
        add_carry = 1'b0;
        for (int i = 0; i < NREGS; i++) begin
            regs_d[i] = regs_q[i];
            wrap_d[i] = 1'b0;
            if (load[i]) begin
                regs_d[i] = xbus_in;
            end else if (add[i]) begin
                // A carry out of the unsigned sum means no borrow when the offset is negative.
                {add_carry, regs_d[i]} = {1'b0, regs_q[i]} + {1'b0, off_ext};
                wrap_d[i] = off_ext[WIDTH-1] ? ~add_carry : add_carry;
            end else if (inc[i] && !dec[i]) begin
                regs_d[i] = regs_q[i] + WIDTH'(1);
                wrap_d[i] = &regs_q[i];
            end else if (dec[i] && !inc[i]) begin
                regs_d[i] = regs_q[i] - WIDTH'(1);
                wrap_d[i] = ~|regs_q[i];
            end
        end
    end

    assign addr_bad = int'(addr_sel) >= NREGS;
    assign xbus_bad = int'(xbus_sel) >= NREGS;

    always_comb begin
        addr_reg = '0;
        xbus_reg = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (int'(addr_sel) == i) addr_reg = regs_q[i];
            if (int'(xbus_sel) == i) xbus_reg = regs_q[i];
        end
    end

    assign sel_err_d = sel_err_q
                     | (addr_oe & addr_bad)
                     | (xbus_oe & xbus_bad)
                     | (|(load & add));

    always_ff @(posedge clock) begin
        if (clear) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= RESET_VAL;
            wrap_q    <= '0;
            sel_err_q <= 1'b0;
        end else begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= regs_d[i];
            wrap_q    <= wrap_d;
            sel_err_q <= sel_err_d;
        end
    end

    // Out-of-range selects still assert drive but present zero, not the displacement.
    assign addr_out   = (addr_oe && !addr_bad) ? addr_reg + disp_ext : '0;
    assign addr_drive = addr_oe;
    assign xbus_out   = (xbus_oe && !xbus_bad) ? xbus_reg : '0;
    assign xbus_drive = xbus_oe;
    assign wrap       = wrap_q;
    assign sel_err    = sel_err_q;

endmodule
